// File: rtl/pb_gesture_decode.sv
// Groups button releases separated by less than an inactivity window into a
// press-count gesture and offers the count downstream over valid/ready.
//
//   state | meaning
//   IDLE  | no gesture in progress
//   COUNT | gesture open, counting releases, window timer running
//   EMIT  | gesture complete, cmd offered and held until accepted
module pb_gesture_decode #(
    parameter int WIN_CYC   = 1_000_000,
    parameter int MAX_PRESS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       released,
    output logic [1:0] cmd,
    output logic       cmd_vld,
    input  logic       cmd_rdy,
    output logic       dropped
);

    localparam int              TW         = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(WIN_CYC - 1);
    localparam logic [1:0]      COUNT_MAX  = 2'(MAX_PRESS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    count_q, count_d;
    logic [1:0]    cmd_d;
    logic          cmd_vld_d;
    logic          dropped_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= 2'd0;
            cmd     <= 2'd0;
            cmd_vld <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            cmd     <= cmd_d;
            cmd_vld <= cmd_vld_d;
            dropped <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        count_d   = count_q;
        cmd_d     = cmd;
        cmd_vld_d = cmd_vld;
        dropped_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (released) begin
                    state_d = COUNT;
                    count_d = 2'd1;
                    timer_d = '0;
                end
            end

            COUNT: begin
                if (released) begin
                    // Releases past saturation still restart the window.
                    timer_d = '0;
                    if (count_q < COUNT_MAX) begin
                        count_d = count_q + 2'd1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = EMIT;
                    cmd_d     = count_q;
                    cmd_vld_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            EMIT: begin
                if (cmd_rdy) begin
                    cmd_vld_d = 1'b0;
                    if (released) begin
                        // Accepting edge doubles as the first press of the next gesture.
                        state_d = COUNT;
                        count_d = 2'd1;
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (released) begin
                    dropped_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                cmd_vld_d = 1'b0;
            end
        endcase
    end

endmodule
